mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares the single downstream memory port between the instruction-fetch requester (I side) and the load/store requester (D side) of the pipelined core. Grants one requester at a time and holds the grant until that transaction's final beat completes. Routes responses back to the granted side only. Its per-side ready/last outputs become the i_data_ok/d_data_ok inputs of the hazard unit.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data beat width
LEN_W, 4, burst length field width; the field encodes beats minus 1 (max 16 beats)

Ports:
clk  in  1  core clock; all state updates on rising edge
resetn  in  1  synchronous active-low reset, sampled on rising edge of clk
i_valid  in  1  I-side request valid; held high and stable until the I-side last beat completes
i_is_write  in  1  I-side write flag; tied 0 in the core, supported anyway
i_addr  in  ADDR_W  I-side start address
i_len  in  LEN_W  I-side beats minus 1
i_wdata  in  DATA_W  I-side current write beat
i_strobe  in  DATA_W/8  I-side byte enables
i_ready  out  1  I-side beat accepted
i_last  out  1  I-side final beat accepted
i_rdata  out  DATA_W  I-side read data
d_valid, d_is_write, d_addr, d_len, d_wdata, d_strobe  in  as I side  D-side request, same rules as the I side
d_ready, d_last, d_rdata  out  as I side  D-side response
m_valid  out  1  downstream request valid
m_is_write, m_addr, m_len, m_wdata, m_strobe  out  as above  downstream request fields, muxed from the owner
m_ready  in  1  downstream beat accepted
m_last  in  1  downstream final beat
m_rdata  in  DATA_W  downstream read data
proto_err  out  1  sticky protocol-error flag
busy  out  1  a transaction is owned

Behaviour:
- Reset (resetn=0 at edge): state=IDLE, owner=none, beat_cnt=0, proto_err=0, rr_ptr=I. While in IDLE, all of m_valid, i_ready, i_last, d_ready, d_last and busy are 0.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - d_valid=1 → GRANT_D (fixed priority, D over I).
  - else i_valid=1 → GRANT_I.
  - else stay in IDLE.
  - Arbitration costs exactly 1 cycle: m_valid is first asserted the cycle after the grant edge.
- GRANT_x:
  - m_* request fields come from x. m_valid = x_valid.
  - x_ready = m_ready & m_valid. x_last = m_ready & m_valid & m_last. x_rdata = m_rdata.
  - The non-owner sees ready=0 and last=0. Its rdata equals m_rdata but is don't-care.
  - busy=1.
- beat_cnt: cleared on grant; increments on each m_valid & m_ready. It is LEN_W+1 bits, so it never wraps for a legal burst.
- Return to IDLE: on the edge where m_valid & m_ready & m_last. There is no back-to-back grant; at least one IDLE cycle separates transactions.
- proto_err is set (sticky until reset) on either condition:
  - m_last accepted while beat_cnt != owner len;
  - a beat is accepted with beat_cnt == len+1 without last.
- Owner drops valid mid-transaction: ownership is kept and m_valid=0 follows. The other side cannot be granted until the owner's last completes.
- A request arriving while BUSY waits. Its valid must stay asserted; the arbiter does not queue it.
- Reset mid-transaction: IDLE next cycle, m_valid=0. Downstream abort handling is the memory side's responsibility.
- Simultaneous: owner last completing plus the other side valid in the same cycle → IDLE, then grant on the following edge.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: adds a 1-bit rr_ptr. In IDLE with both sides valid, the side named by rr_ptr wins. On each grant, rr_ptr moves to the non-granted side. With a single side valid, that side wins regardless of rr_ptr.
- Undefined: fixed D-over-I priority; rr_ptr is not implemented.

Test Plan:
- Single I read, i_len=0, addr 0xBFC00000, m_ready after 2 cycles with m_last=1, rdata 0x24080001 → i_ready=i_last=1 for one cycle, i_rdata=0x24080001, back to IDLE, proto_err=0.
- I and D valid in the same IDLE cycle, both len=0 → D granted first, I granted 1 IDLE cycle after D last. With ARB_ROUND_ROBIN_EN and rr_ptr=I, I goes first.
- D write burst, d_len=3, data 0x11,0x22,0x33,0x44, m_ready every cycle, m_last on beat 4 → m_wdata sequence matches, d_ready 4 cycles, d_last on the 4th, i_ready stays 0 throughout.
- I burst len=3 with m_last asserted on beat 2 → proto_err=1 and stays 1 through later legal transactions, until resetn=0.
- resetn=0 during beat 2 of a D len=3 burst → next cycle m_valid=0, busy=0, d_ready=0; a new I request is then granted normally.
- D owner drops d_valid for 3 cycles mid-burst while i_valid=1 → m_valid=0 for those cycles, I not granted, burst resumes, I granted after D last.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory port between the instruction-fetch (I) and
// load/store (D) requesters. One owner at a time; the grant is held until the owner's final
// beat is accepted, then at least one idle cycle passes before the next grant.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   i_valid/i_is_write/i_addr/...   I-side request; i_ready/i_last/i_rdata response
//   d_valid/d_is_write/d_addr/...   D-side request; d_ready/d_last/d_rdata response
//   m_valid/m_is_write/m_addr/...   downstream request muxed from the owner
//   m_ready/m_last/m_rdata          downstream beat handshake and read data
//   proto_err                       sticky: last-beat / burst-length disagreement seen
//   busy                            a transaction is owned
//
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests alternate
// between sides via rr_ptr; otherwise D always wins over I.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic              i_is_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W/8-1:0] i_strobe,
  output logic              i_ready,
  output logic              i_last,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic              d_is_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W/8-1:0] d_strobe,
  output logic              d_ready,
  output logic              d_last,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic              m_is_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]  m_len,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_strobe,
  input  logic              m_ready,
  input  logic              m_last,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              proto_err,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

  localparam logic [LEN_W:0] CntOne = 1;

  state_e         r_state, w_state_nxt;
  logic [LEN_W:0] r_beat_cnt, w_beat_cnt_nxt;
  logic           r_proto_err, w_proto_err_nxt;
  logic           w_own_i, w_own_d, w_beat, w_pick_d;
  logic [LEN_W:0] w_len_ext, w_len_plus1;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: I wins a tie, 1: D wins a tie
  logic r_rr_ptr, w_rr_ptr_nxt;
  assign w_pick_d = d_valid & (~i_valid | r_rr_ptr);
`else
  assign w_pick_d = d_valid;
`endif

  assign w_own_i = (r_state == StGrantI);
  assign w_own_d = (r_state == StGrantD);

  // Request fields follow the owner; outside a grant m_valid is 0 so the mux value is moot.
  always_comb begin
    m_valid    = 1'b0;
    m_is_write = w_own_d ? d_is_write : i_is_write;
    m_addr     = w_own_d ? d_addr     : i_addr;
    m_len      = w_own_d ? d_len      : i_len;
    m_wdata    = w_own_d ? d_wdata    : i_wdata;
    m_strobe   = w_own_d ? d_strobe   : i_strobe;
    if (w_own_i) m_valid = i_valid;
    if (w_own_d) m_valid = d_valid;
  end

  assign w_beat      = m_valid & m_ready;
  assign i_ready     = w_own_i & w_beat;
  assign i_last      = i_ready & m_last;
  assign d_ready     = w_own_d & w_beat;
  assign d_last      = d_ready & m_last;
  assign i_rdata     = m_rdata;
  assign d_rdata     = m_rdata;
  assign busy        = (r_state != StIdle);
  assign proto_err   = r_proto_err;
  assign w_len_ext   = {1'b0, m_len};
  assign w_len_plus1 = w_len_ext + CntOne;

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_proto_err_nxt = r_proto_err;
`ifdef ARB_ROUND_ROBIN_EN
    w_rr_ptr_nxt    = r_rr_ptr;
`endif
    case (r_state)
      StIdle: begin
        w_beat_cnt_nxt = '0;
        if (w_pick_d) begin
          w_state_nxt = StGrantD;
`ifdef ARB_ROUND_ROBIN_EN
          w_rr_ptr_nxt = 1'b0;
`endif
        end else if (i_valid) begin
          w_state_nxt = StGrantI;
`ifdef ARB_ROUND_ROBIN_EN
          w_rr_ptr_nxt = 1'b1;
`endif
        end
      end
      StGrantI, StGrantD: begin
        if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + CntOne;
          // Memory's idea of the final beat must agree with the requested length.
          if (m_last && (r_beat_cnt != w_len_ext)) w_proto_err_nxt = 1'b1;
          if (!m_last && (r_beat_cnt == w_len_plus1)) w_proto_err_nxt = 1'b1;
          if (m_last) w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_beat_cnt  <= '0;
      r_proto_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_proto_err <= w_proto_err_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr    <= w_rr_ptr_nxt;
`endif
    end
  end

endmodule
